// File: rtl/MD_pkg.sv
// rtl/MD_pkg.sv - shared sizing and state type for the position cache init sequencer
// Purpose: cache geometry parameters and the sequencer FSM state encoding.
// Contents: NUM_CELLS, NUM_INIT_STEPS, PARTICLE_ID_WIDTH, OFFSET_STRUCT_WIDTH,
//           ELEMENT_WIDTH, derived widths, init_seq_state_t.
package MD_pkg;

   localparam int NUM_CELLS           = 27;
   localparam int NUM_INIT_STEPS      = 4;
   localparam int PARTICLE_ID_WIDTH   = 8;
   localparam int OFFSET_STRUCT_WIDTH = 81;
   localparam int ELEMENT_WIDTH       = 2;

   localparam int STEP_WIDTH     = $clog2(NUM_INIT_STEPS);
   localparam int DATA_WIDTH     = NUM_CELLS * OFFSET_STRUCT_WIDTH;
   localparam int ELEM_BUS_WIDTH = NUM_CELLS * ELEMENT_WIDTH;

   // Largest slot count per step; requests above this are clamped.
   localparam logic [PARTICLE_ID_WIDTH:0] MAX_SLOTS =
      (PARTICLE_ID_WIDTH + 1)'(2 ** PARTICLE_ID_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3
   } init_seq_state_t;

endpackage

// File: rtl/pos_cache_init_sequencer.sv
// rtl/pos_cache_init_sequencer.sv - sequences the initial position cache load from a host stream
// Purpose: accepts num_slots * NUM_INIT_STEPS host beats, turns each into a
//          registered cache init write (slot address, one-hot step enable,
//          per-cell payload), then pulses o_PE_start and waits for the run to end.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_cfg_start, i_cfg_num_slots load request and slots per step (IDLE only)
//   i_s_valid/o_s_ready          host beat handshake, ready only in LOAD
//   i_s_data, i_s_element        per-cell positions and element tags
//   i_s_last                     host marker for the final beat of the load
//   i_iter_target_reached        run finished, return to IDLE
//   o_init_wr_addr/_data/_element/_wr_en  cache init write port (1-cycle latency)
//   o_PE_start                   one-cycle start pulse, one cycle after final write
//   o_busy, o_err_last, o_debug_state     status
module pos_cache_init_sequencer
   import MD_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_cfg_start,
   input  logic [PARTICLE_ID_WIDTH:0]    i_cfg_num_slots,
   input  logic                          i_s_valid,
   output logic                          o_s_ready,
   input  logic [DATA_WIDTH-1:0]         i_s_data,
   input  logic [ELEM_BUS_WIDTH-1:0]     i_s_element,
   input  logic                          i_s_last,
   input  logic                          i_iter_target_reached,
   output logic [PARTICLE_ID_WIDTH-1:0]  o_init_wr_addr,
   output logic [DATA_WIDTH-1:0]         o_init_data,
   output logic [ELEM_BUS_WIDTH-1:0]     o_init_element,
   output logic [NUM_INIT_STEPS-1:0]     o_init_wr_en,
   output logic                          o_PE_start,
   output logic                          o_busy,
   output logic                          o_err_last,
   output logic [2:0]                    o_debug_state
);

   localparam logic [PARTICLE_ID_WIDTH-1:0] SLOT_ONE = 1;
   localparam logic [STEP_WIDTH-1:0]        STEP_ONE = 1;
   localparam logic [STEP_WIDTH-1:0]        STEP_LAST = STEP_WIDTH'(NUM_INIT_STEPS - 1);
   localparam logic [NUM_INIT_STEPS-1:0]    EN_ONE   = 1;

   init_seq_state_t state, state_next;

   // Only num_slots-1 is kept: it is the wrap point of the slot counter.
   logic [PARTICLE_ID_WIDTH-1:0] last_slot;
   logic [PARTICLE_ID_WIDTH-1:0] cfg_last_slot;
   logic [PARTICLE_ID_WIDTH-1:0] slot;
   logic [STEP_WIDTH-1:0]        step;
   logic                         cfg_zero;
   logic                         accept;
   logic                         slot_wrap;
   logic                         final_beat;

   assign o_s_ready     = (state == ST_LOAD);
   assign accept        = i_s_valid & o_s_ready;
   assign slot_wrap     = (slot == last_slot);
   assign final_beat    = slot_wrap & (step == STEP_LAST);
   assign cfg_zero      = (i_cfg_num_slots == '0);
   assign o_busy        = (state != ST_IDLE);
   assign o_debug_state = state;

   // Clamp oversize requests to a full slot range; a zero request never
   // reaches LOAD, so its wrap value is irrelevant.
   always_comb begin
      cfg_last_slot = '1;
      if (i_cfg_num_slots < MAX_SLOTS) begin
         cfg_last_slot = i_cfg_num_slots[PARTICLE_ID_WIDTH-1:0] - SLOT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (i_cfg_start) state_next = cfg_zero ? ST_START : ST_LOAD;
         ST_LOAD:  if (accept && final_beat) state_next = ST_START;
         ST_START: state_next = ST_RUN;
         ST_RUN:   if (i_iter_target_reached) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_slot      <= '0;
         slot           <= '0;
         step           <= '0;
         o_err_last     <= 1'b0;
         o_PE_start     <= 1'b0;
         o_init_wr_addr <= '0;
         o_init_wr_en   <= '0;
         o_init_data    <= '0;
         o_init_element <= '0;
      end else begin
         // START lasts one cycle, so registering it yields the single pulse
         // one cycle after the final write appears.
         o_PE_start   <= (state == ST_START);
         o_init_wr_en <= '0;

         if (state == ST_IDLE && i_cfg_start) begin
            last_slot  <= cfg_last_slot;
            slot       <= '0;
            step       <= '0;
            o_err_last <= 1'b0;
         end

         if (accept) begin
            o_init_wr_addr <= slot;
            o_init_wr_en   <= EN_ONE << step;
            o_init_data    <= i_s_data;
            o_init_element <= i_s_element;
            // Load length is governed by the count; i_s_last is only audited.
            if (i_s_last != final_beat) begin
               o_err_last <= 1'b1;
            end
            if (slot_wrap) begin
               slot <= '0;
               step <= step + STEP_ONE;
            end else begin
               slot <= slot + SLOT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_pos_cache_init_sequencer.sv
// tb/tb_pos_cache_init_sequencer.sv - self-checking bench for pos_cache_init_sequencer
module tb_pos_cache_init_sequencer;
   import MD_pkg::*;

   localparam int DW = NUM_CELLS * OFFSET_STRUCT_WIDTH;
   localparam int EW = NUM_CELLS * ELEMENT_WIDTH;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         i_cfg_start;
   logic [PARTICLE_ID_WIDTH:0]   i_cfg_num_slots;
   logic                         i_s_valid;
   logic                         o_s_ready;
   logic [DW-1:0]                i_s_data;
   logic [EW-1:0]                i_s_element;
   logic                         i_s_last;
   logic                         i_iter_target_reached;
   logic [PARTICLE_ID_WIDTH-1:0] o_init_wr_addr;
   logic [DW-1:0]                o_init_data;
   logic [EW-1:0]                o_init_element;
   logic [NUM_INIT_STEPS-1:0]    o_init_wr_en;
   logic                         o_PE_start;
   logic                         o_busy;
   logic                         o_err_last;
   logic [2:0]                   o_debug_state;

   int errors = 0;
   int checks = 0;

   pos_cache_init_sequencer dut (
      .clk(clk), .rst(rst),
      .i_cfg_start(i_cfg_start), .i_cfg_num_slots(i_cfg_num_slots),
      .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
      .i_s_data(i_s_data), .i_s_element(i_s_element), .i_s_last(i_s_last),
      .i_iter_target_reached(i_iter_target_reached),
      .o_init_wr_addr(o_init_wr_addr), .o_init_data(o_init_data),
      .o_init_element(o_init_element), .o_init_wr_en(o_init_wr_en),
      .o_PE_start(o_PE_start), .o_busy(o_busy), .o_err_last(o_err_last),
      .o_debug_state(o_debug_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed cache writes and events, sampled on the falling edge.
   typedef struct {
      logic [PARTICLE_ID_WIDTH-1:0] addr;
      logic [NUM_INIT_STEPS-1:0]    en;
      logic [DW-1:0]                data;
      logic [EW-1:0]                elem;
      int                           c;
   } wr_t;

   wr_t wr_q[$];
   int  pe_q[$];
   int  err_cyc = -1;
   int  ready_cnt = 0;
   bit  prev_err = 1'b0;

   always @(negedge clk) begin
      if (o_init_wr_en != '0)
         wr_q.push_back('{o_init_wr_addr, o_init_wr_en, o_init_data, o_init_element, cyc});
      if (o_PE_start) pe_q.push_back(cyc);
      if (o_err_last && !prev_err && err_cyc < 0) err_cyc = cyc;
      prev_err = o_err_last;
      if (o_s_ready) ready_cnt++;
   end

   // Reference: accepted beats, their payloads, last flags and accept cycles.
   logic [DW-1:0] exp_data[$];
   logic [EW-1:0] exp_elem[$];
   bit            last_q[$];
   int            acc_cyc[$];
   int            start_cyc;

   task automatic clear_model();
      wr_q.delete(); pe_q.delete();
      exp_data.delete(); exp_elem.delete(); last_q.delete(); acc_cyc.delete();
      err_cyc = -1; ready_cnt = 0;
   endtask

   task automatic start_load(input int n);
      @(negedge clk);
      i_cfg_start = 1'b1;
      i_cfg_num_slots = (PARTICLE_ID_WIDTH + 1)'(n);
      start_cyc = cyc;
      @(negedge clk);
      i_cfg_start = 1'b0;
   endtask

   task automatic drive_beats(input int nb, input bit toggle, input int last_at);
      int sent = 0;
      int guard = 0;
      bit phase = 1'b0;
      logic [DW+31:0] tmp;
      logic [31:0] etmp;
      while (sent < nb && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (toggle && phase) begin
            i_s_valid = 1'b0;
            i_s_last = 1'b0;
         end else begin
            for (int w = 0; w < DW; w += 32) tmp[w +: 32] = $urandom;
            etmp = $urandom;
            i_s_data = tmp[DW-1:0];
            i_s_element = etmp[EW-1:0];
            i_s_last = (sent == last_at);
            i_s_valid = 1'b1;
            if (o_s_ready) begin
               exp_data.push_back(i_s_data);
               exp_elem.push_back(i_s_element);
               last_q.push_back(i_s_last);
               acc_cyc.push_back(cyc);
               sent++;
            end
         end
         phase = ~phase;
      end
      @(negedge clk);
      i_s_valid = 1'b0;
      i_s_last = 1'b0;
      if (sent < nb) begin
         errors++; checks++;
         $display("FAIL beats_timeout: accepted %0d, required %0d", sent, nb);
      end
   endtask

   task automatic check_load(input string tag, input int n);
      int n_eff = (n > 2 ** PARTICLE_ID_WIDTH) ? 2 ** PARTICLE_ID_WIDTH : n;
      int g = 0;
      int total = acc_cyc.size();
      int m;
      int exp_err = -1;
      while (pe_q.size() == 0 && g < 20) begin @(negedge clk); g++; end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_q.size() != total) begin
         errors++;
         $display("FAIL %s write_count: got %0d, expected %0d", tag, wr_q.size(), total);
      end
      m = (wr_q.size() < total) ? wr_q.size() : total;
      for (int i = 0; i < m; i++) begin
         logic [PARTICLE_ID_WIDTH-1:0] ea = PARTICLE_ID_WIDTH'(i % n_eff);
         logic [NUM_INIT_STEPS-1:0] ee = NUM_INIT_STEPS'(1 << (i / n_eff));
         checks++;
         if (wr_q[i].addr !== ea) begin
            errors++;
            $display("FAIL %s addr[%0d]: got %0d, expected %0d", tag, i, wr_q[i].addr, ea);
         end
         checks++;
         if (wr_q[i].en !== ee) begin
            errors++;
            $display("FAIL %s wr_en[%0d]: got %b, expected %b", tag, i, wr_q[i].en, ee);
         end
         checks++;
         if (wr_q[i].data !== exp_data[i] || wr_q[i].elem !== exp_elem[i]) begin
            errors++;
            $display("FAIL %s payload[%0d]: elem got %h, expected %h", tag, i, wr_q[i].elem, exp_elem[i]);
         end
         checks++;
         if (wr_q[i].c != acc_cyc[i] + 1) begin
            errors++;
            $display("FAIL %s write_cycle[%0d]: got %0d, expected %0d", tag, i, wr_q[i].c, acc_cyc[i] + 1);
         end
      end
      checks++;
      if (pe_q.size() != 1 || total == 0 || pe_q[0] != acc_cyc[total-1] + 2) begin
         errors++;
         $display("FAIL %s pe_start: pulses %0d first at %0d, expected 1 at %0d", tag, pe_q.size(),
                  (pe_q.size() > 0) ? pe_q[0] : -1, (total > 0) ? acc_cyc[total-1] + 2 : -1);
      end
      for (int i = 0; i < total; i++) begin
         if (last_q[i] != (i == total - 1)) begin
            exp_err = acc_cyc[i] + 1;
            break;
         end
      end
      checks++;
      if (err_cyc != exp_err) begin
         errors++;
         $display("FAIL %s err_last_cycle: got %0d, expected %0d", tag, err_cyc, exp_err);
      end
   endtask

   task automatic finish_run();
      @(negedge clk);
      i_iter_target_reached = 1'b1;
      @(negedge clk);
      i_iter_target_reached = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (o_init_wr_en !== '0 || o_init_wr_addr !== '0 || o_init_data !== '0 || o_init_element !== '0) begin
         errors++;
         $display("FAIL reset_write_port: en %b addr %0d, expected all zero", o_init_wr_en, o_init_wr_addr);
      end
      checks++;
      if (o_PE_start !== 1'b0 || o_busy !== 1'b0 || o_err_last !== 1'b0 || o_s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: pe %b busy %b err %b ready %b, expected 0", o_PE_start, o_busy, o_err_last, o_s_ready);
      end
      checks++;
      if (o_debug_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected 0", o_debug_state);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      clear_model();
      start_load(3);
      drive_beats(12, 1'b0, 11);
      check_load("b2b", 3);
      finish_run();
   endtask

   task automatic test_toggle_valid();
      clear_model();
      start_load(3);
      drive_beats(12, 1'b1, 11);
      check_load("toggle", 3);
      finish_run();
   endtask

   task automatic test_zero_slots();
      int g = 0;
      clear_model();
      start_load(0);
      while (pe_q.size() == 0 && g < 20) begin @(negedge clk); g++; end
      repeat (2) @(negedge clk);
      checks++;
      if (pe_q.size() != 1 || pe_q[0] != start_cyc + 2) begin
         errors++;
         $display("FAIL zero_pe_start: pulses %0d first at %0d, expected 1 at %0d", pe_q.size(),
                  (pe_q.size() > 0) ? pe_q[0] : -1, start_cyc + 2);
      end
      checks++;
      if (ready_cnt != 0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL zero_no_ready: ready cycles %0d writes %0d, expected 0", ready_cnt, wr_q.size());
      end
      finish_run();
   endtask

   task automatic test_err_last();
      clear_model();
      start_load(3);
      drive_beats(12, 1'b0, 4);
      check_load("err_last", 3);
      finish_run();
   endtask

   task automatic test_random_missing_last();
      int n = $urandom_range(1, 5);
      bit tg = 1'($urandom_range(0, 1));
      clear_model();
      start_load(n);
      drive_beats(n * NUM_INIT_STEPS, tg, -1);
      check_load("rand_no_last", n);
      finish_run();
   endtask

   task automatic test_clamp();
      clear_model();
      start_load(300);
      drive_beats(256 * NUM_INIT_STEPS, 1'b0, 256 * NUM_INIT_STEPS - 1);
      check_load("clamp", 300);
      finish_run();
   endtask

   task automatic test_reset_mid_load();
      clear_model();
      start_load(3);
      drive_beats(6, 1'b0, -1);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_init_wr_en !== '0 || o_busy !== 1'b0 || o_debug_state !== 3'd0) begin
         errors++;
         $display("FAIL midload_reset: en %b busy %b state %0d, expected 0", o_init_wr_en, o_busy, o_debug_state);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_model();
      start_load(2);
      drive_beats(8, 1'b0, 7);
      check_load("restart", 2);
   endtask

   task automatic test_start_during_run();
      int g = 0;
      // Still in RUN from the previous load.
      @(negedge clk);
      i_cfg_start = 1'b1;
      i_cfg_num_slots = 9'd3;
      @(negedge clk);
      i_cfg_start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (o_busy !== 1'b1 || o_debug_state !== 3'd3 || o_s_ready !== 1'b0) begin
         errors++;
         $display("FAIL run_ignores_start: busy %b state %0d ready %b, expected 1 3 0", o_busy, o_debug_state, o_s_ready);
      end
      finish_run();
      checks++;
      if (o_busy !== 1'b0 || o_debug_state !== 3'd0) begin
         errors++;
         $display("FAIL run_to_idle: busy %b state %0d, expected 0 0", o_busy, o_debug_state);
      end
      clear_model();
      start_load(0);
      while (pe_q.size() == 0 && g < 20) begin @(negedge clk); g++; end
      checks++;
      if (pe_q.size() != 1 || pe_q[0] != start_cyc + 2) begin
         errors++;
         $display("FAIL restart_after_run: pulses %0d, expected 1 at %0d", pe_q.size(), start_cyc + 2);
      end
      finish_run();
   endtask

   initial begin
      rst = 1'b1;
      i_cfg_start = 1'b0;
      i_cfg_num_slots = '0;
      i_s_valid = 1'b0;
      i_s_data = '0;
      i_s_element = '0;
      i_s_last = 1'b0;
      i_iter_target_reached = 1'b0;
      test_reset();
      test_back_to_back();
      test_toggle_valid();
      test_zero_slots();
      test_err_last();
      test_random_missing_last();
      test_clamp();
      test_reset_mid_load();
      test_start_during_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
